// File: rtl/io_sched_pkg.sv
// Shared types and helpers for the io_sched port scheduler.
package io_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2
    } sched_state_e;

    // Ceiling log2, evaluated at elaboration for widths.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int i = 0; i < 32; i++) begin
            if (value > (32'd1 << i)) result = i + 1;
        end
        return result;
    endfunction

    // Index of the lowest set bit; 0 when no bit is set.
    function automatic int unsigned first_one(input logic [31:0] vec);
        int unsigned idx;
        idx = 0;
        for (int i = 31; i >= 0; i--) begin
            if (vec[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/io_fifo.sv
// Synchronous FIFO with flush. Pointers wrap modulo FDEPTH; the count carries one
// extra bit so that full and empty never alias.
module io_fifo
    import io_sched_pkg::*;
#(
    parameter int unsigned NUBITS = 31,
    parameter int unsigned FDEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic                       pop,
    input  logic [NUBITS-1:0]          wdata,
    output logic [NUBITS-1:0]          head,
    output logic                       empty,
    output logic                       full,
    output logic [clog2(FDEPTH):0]     count
);

    localparam int unsigned AW = clog2(FDEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW + 1)'(FDEPTH);

    logic [NUBITS-1:0] mem [FDEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       cnt;
    logic              do_push;
    logic              do_pop;

    // Status and gated strobes; a push while full or pop while empty is ignored.
    always_comb begin
        empty   = (cnt == '0);
        full    = (cnt == CNT_FULL);
        do_push = push & ~full;
        do_pop  = pop & ~empty;
        head    = mem[rd_ptr];
        count   = cnt;
    end

    // Storage, pointers and occupancy; reset clears contents, flush only empties.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < FDEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + PTR_ONE;
            end
            if (do_pop) rd_ptr <= rd_ptr + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CNT_ONE;
                2'b01:   cnt <= cnt - CNT_ONE;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/io_sched.sv
// Port scheduler between streaming sources/sinks and the processor I/O strobes.
// Input words are buffered per port and served on io_in with zero latency; processor
// writes are buffered per output port. The processor stays in reset until every
// input FIFO holds a word.
// Optional: define IO_SCHED_STATS_EN to add saturating underflow/overflow counters
// (ports udf_cnt, ovf_cnt, parameter CNTW).
module io_sched
    import io_sched_pkg::*;
#(
    parameter int unsigned NUBITS = 31,
    parameter int unsigned NUIOIN = 4,
    parameter int unsigned NUIOOU = 4,
    parameter int unsigned FDEPTH = 4
`ifdef IO_SCHED_STATS_EN
    ,
    parameter int unsigned CNTW   = 16
`endif
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic [NUIOIN*NUBITS-1:0] s_data,
    input  logic [NUIOIN-1:0]        s_valid,
    output logic [NUIOIN-1:0]        s_ready,
    input  logic [NUIOIN-1:0]        req_in,
    output logic [NUBITS-1:0]        io_in,
    input  logic [NUBITS-1:0]        io_out,
    input  logic [NUIOOU-1:0]        out_en,
    output logic [NUIOOU*NUBITS-1:0] m_data,
    output logic [NUIOOU-1:0]        m_valid,
    input  logic [NUIOOU-1:0]        m_ready,
    output logic                     proc_run,
    output logic [1:0]               state,
    output logic [NUIOIN-1:0]        udf,
    output logic [NUIOOU-1:0]        ovf
`ifdef IO_SCHED_STATS_EN
    ,
    output logic [NUIOIN*CNTW-1:0]   udf_cnt,
    output logic [NUIOOU*CNTW-1:0]   ovf_cnt
`endif
);

    localparam int unsigned CW  = clog2(FDEPTH) + 1;
    localparam int unsigned IIW = clog2(NUIOIN);
    localparam int unsigned OIW = clog2(NUIOOU);

    sched_state_e      state_q, state_d;
    logic              proc_run_q;
    logic              flush, active, run, all_primed;

    logic [NUBITS-1:0] in_head  [NUIOIN];
    logic [CW-1:0]     in_cnt   [NUIOIN];
    logic [NUIOIN-1:0] in_empty, in_full, in_push, in_pop;
    logic [NUBITS-1:0] hold_q   [NUIOIN];
    logic [NUIOIN-1:0] udf_q;
    logic [IIW-1:0]    rd_idx;
    logic              rd_hit;

    logic [NUBITS-1:0] out_head [NUIOOU];
    logic [CW-1:0]     out_cnt  [NUIOOU];
    logic [NUIOOU-1:0] out_empty, out_full, out_push, out_pop;
    logic [NUIOOU-1:0] ovf_q;
    logic [OIW-1:0]    wr_idx;
    logic              wr_hit;

    // Every transition into IDLE (and every IDLE cycle) empties the FIFOs.
    assign flush    = (state_d == ST_IDLE);
    assign active   = (state_q != ST_IDLE);
    assign run      = (state_q == ST_RUN);
    assign proc_run = proc_run_q;
    assign state    = state_q;
    assign udf      = udf_q;
    assign ovf      = ovf_q;

    // Next-state logic; dropping enable wins from any state.
    always_comb begin
        all_primed = 1'b1;
        for (int k = 0; k < NUIOIN; k++) begin
            if (in_cnt[k] == '0) all_primed = 1'b0;
        end
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (enable) state_d = ST_PRIME;
            ST_PRIME: if (all_primed) state_d = ST_RUN;
            ST_RUN:   state_d = ST_RUN;
            default:  state_d = ST_IDLE;
        endcase
        if (!enable) state_d = ST_IDLE;
    end

    // State register and registered processor release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            proc_run_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            proc_run_q <= (state_d == ST_RUN);
        end
    end

    // Input side: stream acceptance and zero-latency serve of the selected head.
    always_comb begin
        rd_idx = IIW'(first_one(32'(req_in)));
        rd_hit = run & (|req_in);
        io_in  = '0;
        in_pop = '0;
        for (int k = 0; k < NUIOIN; k++) begin
            s_ready[k] = active & ~in_full[k];
            in_push[k] = s_valid[k] & s_ready[k];
        end
        if (rd_hit) begin
            if (in_empty[rd_idx]) begin
                io_in = hold_q[rd_idx];
            end else begin
                io_in          = in_head[rd_idx];
                in_pop[rd_idx] = 1'b1;
            end
        end
    end

    // Output side: processor write into the lowest strobed port, sink drain.
    always_comb begin
        wr_idx   = OIW'(first_one(32'(out_en)));
        wr_hit   = run & (|out_en);
        out_push = '0;
        if (wr_hit && !out_full[wr_idx]) out_push[wr_idx] = 1'b1;
        for (int k = 0; k < NUIOOU; k++) begin
            m_valid[k]                   = (out_cnt[k] != '0);
            out_pop[k]                   = m_ready[k] & ~out_empty[k];
            m_data[k*NUBITS +: NUBITS]   = out_head[k];
        end
    end

    // Sticky error flags and last-served words; hold survives IDLE so an underflow
    // always replays the most recent real word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            udf_q <= '0;
            ovf_q <= '0;
            for (int k = 0; k < NUIOIN; k++) hold_q[k] <= '0;
        end else if (flush) begin
            udf_q <= '0;
            ovf_q <= '0;
        end else begin
            if (rd_hit) begin
                if (in_empty[rd_idx]) udf_q[rd_idx] <= 1'b1;
                else                  hold_q[rd_idx] <= in_head[rd_idx];
            end
            if (wr_hit && out_full[wr_idx]) ovf_q[wr_idx] <= 1'b1;
        end
    end

`ifdef IO_SCHED_STATS_EN
    localparam logic [CNTW-1:0] STAT_MAX = '1;
    localparam logic [CNTW-1:0] STAT_ONE = CNTW'(1);

    logic [CNTW-1:0] udf_cnt_q [NUIOIN];
    logic [CNTW-1:0] ovf_cnt_q [NUIOOU];

    // Saturating per-port event counters, cleared together with the sticky flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < NUIOIN; k++) udf_cnt_q[k] <= '0;
            for (int k = 0; k < NUIOOU; k++) ovf_cnt_q[k] <= '0;
        end else if (flush) begin
            for (int k = 0; k < NUIOIN; k++) udf_cnt_q[k] <= '0;
            for (int k = 0; k < NUIOOU; k++) ovf_cnt_q[k] <= '0;
        end else begin
            if (rd_hit && in_empty[rd_idx] && (udf_cnt_q[rd_idx] != STAT_MAX)) begin
                udf_cnt_q[rd_idx] <= udf_cnt_q[rd_idx] + STAT_ONE;
            end
            if (wr_hit && out_full[wr_idx] && (ovf_cnt_q[wr_idx] != STAT_MAX)) begin
                ovf_cnt_q[wr_idx] <= ovf_cnt_q[wr_idx] + STAT_ONE;
            end
        end
    end

    // Flatten counters onto the ports.
    always_comb begin
        for (int k = 0; k < NUIOIN; k++) udf_cnt[k*CNTW +: CNTW] = udf_cnt_q[k];
        for (int k = 0; k < NUIOOU; k++) ovf_cnt[k*CNTW +: CNTW] = ovf_cnt_q[k];
    end
`endif

    for (genvar k = 0; k < NUIOIN; k++) begin : g_in_fifo
        io_fifo #(
            .NUBITS (NUBITS),
            .FDEPTH (FDEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .flush (flush),
            .push  (in_push[k]),
            .pop   (in_pop[k]),
            .wdata (s_data[k*NUBITS +: NUBITS]),
            .head  (in_head[k]),
            .empty (in_empty[k]),
            .full  (in_full[k]),
            .count (in_cnt[k])
        );
    end

    for (genvar k = 0; k < NUIOOU; k++) begin : g_out_fifo
        io_fifo #(
            .NUBITS (NUBITS),
            .FDEPTH (FDEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .flush (flush),
            .push  (out_push[k]),
            .pop   (out_pop[k]),
            .wdata (io_out),
            .head  (out_head[k]),
            .empty (out_empty[k]),
            .full  (out_full[k]),
            .count (out_cnt[k])
        );
    end

endmodule

// File: tb/tb_io_sched.sv
// Self-checking bench for io_sched: directed scenarios followed by random traffic,
// all checked against a queue-based model of the scheduler's rules.
module tb_io_sched;

    localparam int unsigned NUBITS = 31;
    localparam int unsigned NUIOIN = 4;
    localparam int unsigned NUIOOU = 4;
    localparam int unsigned FDEPTH = 4;
`ifdef IO_SCHED_STATS_EN
    localparam int unsigned CNTW   = 2;
`endif

    logic                     clk = 1'b0;
    logic                     rst = 1'b0;
    logic                     enable = 1'b0;
    logic [NUIOIN*NUBITS-1:0] s_data = '0;
    logic [NUIOIN-1:0]        s_valid = '0;
    logic [NUIOIN-1:0]        s_ready;
    logic [NUIOIN-1:0]        req_in = '0;
    logic [NUBITS-1:0]        io_in;
    logic [NUBITS-1:0]        io_out = '0;
    logic [NUIOOU-1:0]        out_en = '0;
    logic [NUIOOU*NUBITS-1:0] m_data;
    logic [NUIOOU-1:0]        m_valid;
    logic [NUIOOU-1:0]        m_ready = '0;
    logic                     proc_run;
    logic [1:0]               state;
    logic [NUIOIN-1:0]        udf;
    logic [NUIOOU-1:0]        ovf;
`ifdef IO_SCHED_STATS_EN
    logic [NUIOIN*CNTW-1:0]   udf_cnt;
    logic [NUIOOU*CNTW-1:0]   ovf_cnt;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model state.
    logic [NUBITS-1:0] inq  [NUIOIN][$];
    logic [NUBITS-1:0] outq [NUIOOU][$];
    logic [NUBITS-1:0] m_hold [NUIOIN];
    logic [NUIOIN-1:0] m_udf;
    logic [NUIOOU-1:0] m_ovf;
    int                m_state;
`ifdef IO_SCHED_STATS_EN
    int                m_udf_cnt [NUIOIN];
    int                m_ovf_cnt [NUIOOU];
`endif

    io_sched #(
        .NUBITS (NUBITS),
        .NUIOIN (NUIOIN),
        .NUIOOU (NUIOOU),
        .FDEPTH (FDEPTH)
`ifdef IO_SCHED_STATS_EN
        ,
        .CNTW   (CNTW)
`endif
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .s_data   (s_data),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .req_in   (req_in),
        .io_in    (io_in),
        .io_out   (io_out),
        .out_en   (out_en),
        .m_data   (m_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .proc_run (proc_run),
        .state    (state),
        .udf      (udf),
        .ovf      (ovf)
`ifdef IO_SCHED_STATS_EN
        ,
        .udf_cnt  (udf_cnt),
        .ovf_cnt  (ovf_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int lowest(input logic [3:0] v);
        for (int i = 0; i < 4; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    task automatic set_word(input int k, input logic [NUBITS-1:0] w);
        s_data[k*NUBITS +: NUBITS] = w;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NUIOIN; i++) begin
            inq[i].delete();
            m_hold[i] = '0;
        end
        for (int i = 0; i < NUIOOU; i++) outq[i].delete();
        m_udf   = '0;
        m_ovf   = '0;
        m_state = 0;
`ifdef IO_SCHED_STATS_EN
        for (int i = 0; i < NUIOIN; i++) m_udf_cnt[i] = 0;
        for (int i = 0; i < NUIOOU; i++) m_ovf_cnt[i] = 0;
`endif
    endtask

    // Compare every observable output against the model (called between edges).
    task automatic compare_all();
        logic [NUIOIN-1:0] exp_rdy;
        logic [NUIOOU-1:0] exp_mv;
        logic [NUBITS-1:0] exp_io;
        int                k;
        chk("state", state, m_state);
        chk("proc_run", proc_run, m_state == 2);
        for (int i = 0; i < NUIOIN; i++) exp_rdy[i] = (m_state != 0) && (inq[i].size() < FDEPTH);
        chk("s_ready", s_ready, exp_rdy);
        for (int i = 0; i < NUIOOU; i++) begin
            exp_mv[i] = (outq[i].size() > 0);
            if (exp_mv[i]) chk($sformatf("m_data%0d", i), m_data[i*NUBITS +: NUBITS], outq[i][0]);
        end
        chk("m_valid", m_valid, exp_mv);
        chk("udf", udf, m_udf);
        chk("ovf", ovf, m_ovf);
        k      = lowest(req_in);
        exp_io = '0;
        if (m_state == 2 && k >= 0) exp_io = (inq[k].size() > 0) ? inq[k][0] : m_hold[k];
        chk("io_in", io_in, exp_io);
`ifdef IO_SCHED_STATS_EN
        for (int i = 0; i < NUIOIN; i++) chk("udf_cnt", udf_cnt[i*CNTW +: CNTW], m_udf_cnt[i]);
        for (int i = 0; i < NUIOOU; i++) chk("ovf_cnt", ovf_cnt[i*CNTW +: CNTW], m_ovf_cnt[i]);
`endif
    endtask

    // Advance the model by one clock edge using the current inputs.
    task automatic model_step();
        logic [NUIOIN-1:0] rdy;
        bit                primed;
        bit                full;
        int                k;
        int                j;
        if (!enable) begin
            for (int i = 0; i < NUIOIN; i++) inq[i].delete();
            for (int i = 0; i < NUIOOU; i++) outq[i].delete();
            m_udf   = '0;
            m_ovf   = '0;
            m_state = 0;
`ifdef IO_SCHED_STATS_EN
            for (int i = 0; i < NUIOIN; i++) m_udf_cnt[i] = 0;
            for (int i = 0; i < NUIOOU; i++) m_ovf_cnt[i] = 0;
`endif
            return;
        end
        primed = 1'b1;
        for (int i = 0; i < NUIOIN; i++) begin
            rdy[i] = (m_state != 0) && (inq[i].size() < FDEPTH);
            if (inq[i].size() == 0) primed = 1'b0;
        end
        k = lowest(req_in);
        if (m_state == 2 && k >= 0) begin
            if (inq[k].size() > 0) begin
                m_hold[k] = inq[k].pop_front();
            end else begin
                m_udf[k] = 1'b1;
`ifdef IO_SCHED_STATS_EN
                if (m_udf_cnt[k] < (1 << CNTW) - 1) m_udf_cnt[k]++;
`endif
            end
        end
        for (int i = 0; i < NUIOIN; i++) begin
            if (rdy[i] && s_valid[i]) inq[i].push_back(s_data[i*NUBITS +: NUBITS]);
        end
        j = lowest(out_en);
        for (int i = 0; i < NUIOOU; i++) begin
            full = (outq[i].size() == FDEPTH);
            if (m_ready[i] && outq[i].size() > 0) void'(outq[i].pop_front());
            if (m_state == 2 && j == i) begin
                if (full) begin
                    m_ovf[i] = 1'b1;
`ifdef IO_SCHED_STATS_EN
                    if (m_ovf_cnt[i] < (1 << CNTW) - 1) m_ovf_cnt[i]++;
`endif
                end else begin
                    outq[i].push_back(io_out);
                end
            end
        end
        if (m_state == 0)                m_state = 1;
        else if (m_state == 1 && primed) m_state = 2;
    endtask

    // One clock: check at the falling edge, step the model, return just after the edge.
    task automatic cycle();
        @(negedge clk);
        compare_all();
        model_step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        compare_all();
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Priming: three ports filled is not enough, the fourth releases the processor.
        enable = 1'b1;
        cycle();
        set_word(0, 31'h10);
        set_word(1, 31'h11);
        set_word(2, 31'h12);
        s_valid = 4'b0111;
        cycle();
        s_valid = 4'b0000;
        cycle();
        chk("t1_still_prime", state, 2'd1);
        chk("t1_no_run", proc_run, 1'b0);
        set_word(3, 31'h13);
        s_valid = 4'b1000;
        cycle();
        s_valid = 4'b0000;
        cycle();
        chk("t1_run", state, 2'd2);
        chk("t1_proc_run", proc_run, 1'b1);

        // Two reads from port 1, then an underflow that replays the last word.
        set_word(1, 31'h22);
        s_valid = 4'b0010;
        cycle();
        s_valid = 4'b0000;
        req_in  = 4'b0010;
        #1 chk("t2_first", io_in, 31'h11);
        cycle();
        #1 chk("t2_second", io_in, 31'h22);
        cycle();
        #1 chk("t3_hold", io_in, 31'h22);
        cycle();
        req_in = 4'b0000;
        chk("t3_udf", udf, 4'b0010);

        // Five writes into a depth-4 output FIFO, then drain.
        m_ready = 4'b0000;
        out_en  = 4'b0100;
        for (int i = 1; i <= 5; i++) begin
            io_out = NUBITS'(i);
            cycle();
        end
        out_en = 4'b0000;
        chk("t4_head", m_data[2*NUBITS +: NUBITS], 31'd1);
        chk("t4_ovf", ovf, 4'b0100);
        m_ready = 4'b0100;
        for (int i = 1; i <= 4; i++) begin
            chk("t4_drain", m_data[2*NUBITS +: NUBITS], NUBITS'(i));
            cycle();
        end
        chk("t4_empty", m_valid[2], 1'b0);
        m_ready = 4'b0000;

        // Dropping enable with data buffered returns to a clean IDLE.
        for (int i = 0; i < 4; i++) set_word(i, NUBITS'($urandom));
        s_valid = 4'b1111;
        cycle();
        s_valid = 4'b0000;
        out_en  = 4'b0001;
        io_out  = 31'h5a5a;
        cycle();
        out_en = 4'b0000;
        enable = 1'b0;
        cycle();
        chk("t5_idle", state, 2'd0);
        chk("t5_proc_run", proc_run, 1'b0);
        chk("t5_m_valid", m_valid, 4'b0000);
        chk("t5_udf", udf, 4'b0000);
        chk("t5_ovf", ovf, 4'b0000);
        enable = 1'b1;
        cycle();
        cycle();
        chk("t5_flushed", state, 2'd1);

        // Random traffic with occasional enable drops.
        for (int n = 0; n < 600; n++) begin
            int r;
            enable = ($urandom_range(0, 39) != 0);
            for (int i = 0; i < 4; i++) set_word(i, NUBITS'($urandom));
            s_valid = 4'($urandom);
            r = $urandom_range(0, 7);
            req_in = (r < 4) ? 4'(1 << r) : (r == 4) ? 4'b0000 : 4'($urandom);
            r = $urandom_range(0, 7);
            out_en = (r < 4) ? 4'(1 << r) : (r == 4) ? 4'b0000 : 4'($urandom);
            io_out  = NUBITS'($urandom);
            m_ready = 4'($urandom);
            cycle();
        end
        s_valid = '0;
        req_in  = '0;
        out_en  = '0;
        m_ready = '0;

`ifdef IO_SCHED_STATS_EN
        // Underflow counter saturates at its maximum.
        enable = 1'b0;
        cycle();
        enable = 1'b1;
        cycle();
        s_valid = 4'b1111;
        cycle();
        s_valid = 4'b0000;
        cycle();
        req_in = 4'b0001;
        repeat (6) cycle();
        req_in = 4'b0000;
        chk("t6_udf_sat", udf_cnt[CNTW-1:0], 2'd3);
`endif

        // Asynchronous reset in the middle of RUN with output data buffered.
        enable = 1'b0;
        cycle();
        enable  = 1'b1;
        s_valid = 4'b1111;
        repeat (3) cycle();
        s_valid = 4'b0000;
        out_en  = 4'b0001;
        io_out  = 31'h77;
        cycle();
        out_en = 4'b0000;
        chk("t7_pre_valid", m_valid[0], 1'b1);
        #2 rst = 1'b0;
        #1;
        model_reset();
        chk("t7_state", state, 2'd0);
        chk("t7_proc_run", proc_run, 1'b0);
        chk("t7_m_valid", m_valid, 4'b0000);
        chk("t7_s_ready", s_ready, 4'b0000);
        chk("t7_udf_ovf", {udf, ovf}, 8'h00);
        @(posedge clk);
        #1 rst = 1'b1;
        enable = 1'b0;
        cycle();
        cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
